env_playback_rd: RTL

- Read sequencer that drives the narrow read port of the wide-write/narrow-read envelope buffer. It consumes what that buffer produces.
- On a start command it issues a burst of consecutive narrow addresses, starting at a given address, for a given length.
- It absorbs the buffer's fixed read latency and presents the returned samples as a valid/ready stream with a last flag to the downstream DSP stage.
- Single clock domain: the buffer's read-side clock.

---
 rtl/env_playback_rd_if.sv | 31 +++
 rtl/sync_fwft_fifo.sv | 71 +++++++
 rtl/env_playback_rd.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/env_playback_rd_if.sv
// Handshake bundle between the envelope read sequencer and its environment:
// command/status, the buffer's narrow read port and the downstream sample stream.
interface env_playback_rd_if #(
    parameter int unsigned aw = 8,
    parameter int unsigned dw = 8
);
    logic          start;
    logic [aw-1:0] start_addr;
    logic [aw-1:0] length;
    logic          abort;
    logic          busy;
    logic          done;
    logic [aw-1:0] addrb;
    logic [dw-1:0] rdata;
    logic [dw-1:0] dout;
    logic          dout_valid;
    logic          dout_last;
    logic          dout_ready;

    // Environment side: issues commands, supplies buffer data, consumes samples.
    modport master (
        output start, start_addr, length, abort, rdata, dout_ready,
        input  busy, done, addrb, dout, dout_valid, dout_last
    );

    // Sequencer side.
    modport slave (
        input  start, start_addr, length, abort, rdata, dout_ready,
        output busy, done, addrb, dout, dout_valid, dout_last
    );
endinterface

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous flush and occupancy count.
// The head entry is visible on o_rd_data whenever o_valid is high.
module sync_fwft_fifo #(
    parameter int unsigned width = 9,
    parameter int unsigned depth = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_flush,
    input  logic                       i_wr_en,
    input  logic [width-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    output logic [width-1:0]           o_rd_data,
    output logic                       o_valid,
    output logic [$clog2(depth+1)-1:0] o_count
);
    localparam int unsigned PW = (depth > 1) ? $clog2(depth) : 1;
    localparam int unsigned CW = $clog2(depth + 1);

    logic [width-1:0] r_mem [depth];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_rd;
    logic             w_wr;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        f_next = (p == PW'(depth - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_full = (r_count == CW'(depth));
    assign w_rd   = i_rd_en && (r_count != '0);
    // A full FIFO still takes a write when the head leaves on the same edge.
    assign w_wr   = i_wr_en && (!w_full || w_rd);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= i_wr_data;
                r_wptr        <= f_next(r_wptr);
            end
            if (w_rd) begin
                r_rptr <= f_next(r_rptr);
            end
            unique case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rptr];
    assign o_valid   = (r_count != '0);
    assign o_count   = r_count;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(i_wr_en && !i_flush && w_full && !w_rd));
endmodule

// File: rtl/env_playback_rd.sv
// Read sequencer for the envelope buffer's narrow port: issues a burst of addresses,
// absorbs the fixed read latency and streams the returned samples with a last flag.
module env_playback_rd #(
    parameter int unsigned aw  = 8,
    parameter int unsigned dw  = 8,
    parameter int unsigned lat = 2
) (
    input logic             clk,
    input logic             reset,
    env_playback_rd_if.slave bus
);
    localparam int unsigned fifo_depth = lat + 2;
    localparam int unsigned CW = $clog2(fifo_depth + 1);
    localparam logic [CW:0]   DEPTH_L = (CW + 1)'(fifo_depth);
    localparam logic [aw-1:0] ONE     = aw'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t        r_state;
    logic          r_busy;
    logic          r_done;
    logic [aw-1:0] r_addrb;
    logic [aw-1:0] r_remaining;
    // Tag travelling with the address currently held in addrb.
    logic          r_iss_v;
    logic          r_iss_last;
    logic [lat-1:0] r_tag_v;
    logic [lat-1:0] r_tag_last;

    logic [CW-1:0] w_fifo_count;
    logic          w_fifo_valid;
    logic [dw:0]   w_head;
    logic [CW-1:0] w_inflight;
    logic [CW:0]   w_occ;
    logic          w_pop;
    logic          w_credit;

    always_comb begin
        w_inflight = {{(CW-1){1'b0}}, r_iss_v};
        for (int i = 0; i < lat; i++) begin
            w_inflight = w_inflight + {{(CW-1){1'b0}}, r_tag_v[i]};
        end
    end

    // A head accepted on this edge frees its slot, so steady streaming has no bubbles.
    assign w_pop    = w_fifo_valid && bus.dout_ready;
    assign w_occ    = {1'b0, w_fifo_count} + {1'b0, w_inflight} - {{CW{1'b0}}, w_pop};
    assign w_credit = (w_occ < DEPTH_L);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_addrb     <= '0;
            r_remaining <= '0;
            r_iss_v     <= 1'b0;
            r_iss_last  <= 1'b0;
            r_tag_v     <= '0;
            r_tag_last  <= '0;
        end else begin
            r_done        <= 1'b0;
            r_iss_v       <= 1'b0;
            r_iss_last    <= 1'b0;
            r_tag_v[0]    <= r_iss_v;
            r_tag_last[0] <= r_iss_last;
            for (int i = 1; i < lat; i++) begin
                r_tag_v[i]    <= r_tag_v[i-1];
                r_tag_last[i] <= r_tag_last[i-1];
            end
            if (bus.abort && (r_state != ST_IDLE)) begin
                r_state    <= ST_IDLE;
                r_busy     <= 1'b0;
                r_tag_v    <= '0;
                r_tag_last <= '0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (bus.start && !bus.abort) begin
                            if (bus.length == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_addrb     <= bus.start_addr;
                                r_remaining <= bus.length - ONE;
                                r_iss_v     <= 1'b1;
                                r_iss_last  <= (bus.length == ONE);
                                r_state     <= (bus.length == ONE) ? ST_DRAIN : ST_RUN;
                                r_busy      <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (w_credit) begin
                            r_addrb     <= r_addrb + ONE;
                            r_remaining <= r_remaining - ONE;
                            r_iss_v     <= 1'b1;
                            r_iss_last  <= (r_remaining == ONE);
                            if (r_remaining == ONE) begin
                                r_state <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if ((w_fifo_count == '0) && (w_inflight == '0)) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    sync_fwft_fifo #(
        .width (dw + 1),
        .depth (fifo_depth)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_flush   (bus.abort),
        .i_wr_en   (r_tag_v[lat-1]),
        .i_wr_data ({bus.rdata, r_tag_last[lat-1]}),
        .i_rd_en   (bus.dout_ready),
        .o_rd_data (w_head),
        .o_valid   (w_fifo_valid),
        .o_count   (w_fifo_count)
    );

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.addrb      = r_addrb;
    assign bus.dout       = w_head[dw:1];
    assign bus.dout_last  = w_head[0];
    assign bus.dout_valid = w_fifo_valid;
endmodule
